vdg_frame_timing: RTL and testbench

- Parametrised frame/line timing generator for the VDG replacement. It replaces the fixed-format timing stage.
- Produces HSn, FSn, back-porch and active-window flags, byte Load strobes, DA0, the per-pixel enable and the character/graphics row counter.
- Dot-clock timing is generic. NTSC/PAL frame length is chosen per frame.
- Display mode (AnG, GM) is latched at frame start, so mid-frame mode writes cannot tear the picture.

---
 rtl/vdg_frame_timing_if.sv | 31 +++
 rtl/vdg_frame_timing.sv | 179 +++++++++++++++++
 tb/tb_vdg_frame_timing.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/vdg_frame_timing_if.sv
// Bundles the per-frame mode inputs and all timing outputs of the VDG frame timing generator.
// master: the timing generator (drives the timing flags). slave: a display consumer.
// Clock and reset are not part of the bundle; they stay plain ports on the modules.
interface vdg_frame_timing_if #(
  parameter int CNT_W = 10
);
  logic             FrameFormat;
  logic             AnG;
  logic [2:0]       GM;
  logic             HSn;
  logic             FSn;
  logic             BackPorch;
  logic             Active;
  logic             Load;
  logic             PixelEn;
  logic             DA0;
  logic [3:0]       AlphaRow;
  logic             RPn;
  logic [CNT_W-1:0] HCount;
  logic [CNT_W-1:0] VCount;

  modport master (
    input  FrameFormat, AnG, GM,
    output HSn, FSn, BackPorch, Active, Load, PixelEn, DA0, AlphaRow, RPn, HCount, VCount
  );

  modport slave (
    output FrameFormat, AnG, GM,
    input  HSn, FSn, BackPorch, Active, Load, PixelEn, DA0, AlphaRow, RPn, HCount, VCount
  );
endinterface

// File: rtl/vdg_frame_timing.sv
// Frame/line timing generator for the VDG: sync, porch and window flags, byte loads, pixel enables, row counter.
// Latency: timing flags are registered one dot clock after the counter value they decode; HCount/VCount are the live counters.
// No backpressure: free-running from the dot clock; mode and frame format are sampled only at frame start.
module vdg_frame_timing #(
  parameter int CNT_W        = 10,
  parameter int H_TOTAL      = 456,
  parameter int H_SYNC       = 34,
  parameter int H_BACK       = 50,
  parameter int H_ACTIVE     = 256,
  parameter int V_TOTAL_NTSC = 262,
  parameter int V_TOTAL_PAL  = 312,
  parameter int V_SYNC       = 3,
  parameter int V_TOP        = 38,
  parameter int V_ACTIVE     = 192,
  parameter int ROW_HEIGHT   = 12
) (
  input  logic                i_Clk,
  input  logic                i_RSTn,
  vdg_frame_timing_if.master  bus
);

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_TOP  = 2'd1;
  localparam logic [1:0] ST_ACT  = 2'd2;
  localparam logic [1:0] ST_BOT  = 2'd3;

  localparam logic [CNT_W-1:0] L_HLAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] L_HSYNC   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] L_HB0     = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] L_HEND    = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [CNT_W-1:0] L_VLAST_N = CNT_W'(V_TOTAL_NTSC - 1);
  localparam logic [CNT_W-1:0] L_VLAST_P = CNT_W'(V_TOTAL_PAL - 1);
  localparam logic [CNT_W-1:0] L_VTOP    = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] L_VACT    = CNT_W'(V_SYNC + V_TOP);
  localparam logic [CNT_W-1:0] L_VBOT    = CNT_W'(V_SYNC + V_TOP + V_ACTIVE);

  logic [CNT_W-1:0] r_hcnt, r_vcnt;
  logic [1:0]       r_vstate;
  logic             r_first, r_mfmt, r_mang;
  logic [2:0]       r_mgm;
  logic [3:0]       r_row;
  logic             r_hsn, r_fsn, r_bp, r_act, r_load, r_pix, r_da0, r_rpn;

  logic             w_hwrap, w_vlast, w_frame_end, w_hwin, w_act;
  logic [CNT_W-1:0] w_vnext;
  logic [1:0]       w_vst_nxt;
  logic [3:0]       w_d4, w_bmask;
  logic [1:0]       w_pmask;
  logic [4:0]       w_lpr;

  assign w_hwrap     = (r_hcnt == L_HLAST);
  assign w_vlast     = (r_vcnt == (r_mfmt ? L_VLAST_P : L_VLAST_N));
  assign w_frame_end = w_hwrap && w_vlast;
  assign w_vnext     = w_vlast ? '0 : r_vcnt + CNT_W'(1);
  assign w_hwin      = (r_hcnt >= L_HB0) && (r_hcnt < L_HEND);
  assign w_act       = w_hwin && (r_vstate == ST_ACT);
  // Only the low bits of the active dot index matter: byte and pixel pitches are powers of two up to 16.
  assign w_d4        = r_hcnt[3:0] - L_HB0[3:0];

  // Byte/pixel pitch masks and lines per row for the mode latched this frame.
  always_comb begin
    w_bmask = 4'd7;
    w_pmask = 2'd0;
    w_lpr   = 5'(ROW_HEIGHT);
    if (r_mang) begin
      case (r_mgm)
        3'd0:    begin w_bmask = 4'd15; w_pmask = 2'd3; w_lpr = 5'd3; end
        3'd1:    begin w_bmask = 4'd15; w_pmask = 2'd1; w_lpr = 5'd3; end
        3'd2:    begin w_bmask = 4'd7;  w_pmask = 2'd1; w_lpr = 5'd3; end
        3'd3:    begin w_bmask = 4'd15; w_pmask = 2'd1; w_lpr = 5'd2; end
        3'd4:    begin w_bmask = 4'd7;  w_pmask = 2'd1; w_lpr = 5'd2; end
        3'd5:    begin w_bmask = 4'd15; w_pmask = 2'd1; w_lpr = 5'd1; end
        3'd6:    begin w_bmask = 4'd7;  w_pmask = 2'd1; w_lpr = 5'd1; end
        default: begin w_bmask = 4'd7;  w_pmask = 2'd0; w_lpr = 5'd1; end
      endcase
    end
  end

  // Vertical region for the line about to start; line 0 always restarts at SYNC so an empty BOT is skipped.
  always_comb begin
    w_vst_nxt = r_vstate;
    if (w_vnext == '0) begin
      w_vst_nxt = ST_SYNC;
    end else begin
      case (r_vstate)
        ST_SYNC: if (w_vnext == L_VTOP) w_vst_nxt = ST_TOP;
        ST_TOP:  if (w_vnext == L_VACT) w_vst_nxt = ST_ACT;
        ST_ACT:  if (w_vnext == L_VBOT) w_vst_nxt = ST_BOT;
        default: w_vst_nxt = r_vstate;
      endcase
    end
  end

  // Free-running dot and line counters; frame length follows the format latched for this frame.
  always_ff @(posedge i_Clk or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_hwrap) begin
      r_hcnt <= '0;
      r_vcnt <= w_vnext;
    end else begin
      r_hcnt <= r_hcnt + CNT_W'(1);
    end
  end

  // Capture format and mode only at the frame boundary (or the first clock out of reset) to avoid tearing.
  always_ff @(posedge i_Clk or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_first <= 1'b1;
      r_mfmt  <= 1'b0;
      r_mang  <= 1'b0;
      r_mgm   <= 3'd0;
    end else begin
      r_first <= 1'b0;
      if (r_first || w_frame_end) begin
        r_mfmt <= bus.FrameFormat;
        r_mang <= bus.AnG;
        r_mgm  <= bus.GM;
      end
    end
  end

  // Vertical FSM and row-within-character counter, both advanced at line wrap.
  always_ff @(posedge i_Clk or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_vstate <= ST_SYNC;
      r_row    <= 4'd0;
    end else if (w_hwrap) begin
      r_vstate <= w_vst_nxt;
      if (w_vst_nxt != ST_ACT || r_vstate != ST_ACT)
        r_row <= 4'd0;
      else if ({1'b0, r_row} == w_lpr - 5'd1)
        r_row <= 4'd0;
      else
        r_row <= r_row + 4'd1;
    end
  end

  // Registered timing flags decoded from the current counters and state.
  always_ff @(posedge i_Clk or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_hsn  <= 1'b1;
      r_fsn  <= 1'b1;
      r_bp   <= 1'b0;
      r_act  <= 1'b0;
      r_load <= 1'b0;
      r_pix  <= 1'b0;
      r_da0  <= 1'b0;
      r_rpn  <= 1'b1;
    end else begin
      r_hsn  <= (r_hcnt >= L_HSYNC);
      r_bp   <= (r_hcnt >= L_HSYNC) && (r_hcnt < L_HB0);
      r_fsn  <= (r_vstate != ST_SYNC);
      r_act  <= w_act;
      r_load <= w_act && ((w_d4 & w_bmask) == 4'd0);
      r_pix  <= w_act && ((w_d4[1:0] & w_pmask) == 2'd0);
      r_rpn  <= !((r_vstate == ST_ACT) && (r_row == 4'd0) && !r_mang);
      // DA0 clears with the first byte of the window, then flips after each byte load.
      if (r_hcnt == L_HB0)
        r_da0 <= 1'b0;
      else if (r_load)
        r_da0 <= ~r_da0;
    end
  end

  assign bus.HSn       = r_hsn;
  assign bus.FSn       = r_fsn;
  assign bus.BackPorch = r_bp;
  assign bus.Active    = r_act;
  assign bus.Load      = r_load;
  assign bus.PixelEn   = r_pix;
  assign bus.DA0       = r_da0;
  assign bus.AlphaRow  = r_row;
  assign bus.RPn       = r_rpn;
  assign bus.HCount    = r_hcnt;
  assign bus.VCount    = r_vcnt;

endmodule

// File: tb/tb_vdg_frame_timing.sv
// Randomized bench for vdg_frame_timing with a reduced geometry so several frames fit a short run.
// Expected values come from an arithmetic model of the frame (position -> flags), compared every cycle.
// Includes reset at power-up and mid active window, mode/format changes mid-frame.
module tb_vdg_frame_timing;
  localparam int CNT_W    = 10;
  localparam int H_TOTAL  = 40;
  localparam int H_SYNC   = 4;
  localparam int H_BACK   = 4;
  localparam int H_ACTIVE = 16;
  localparam int VT_N     = 24;
  localparam int VT_P     = 28;
  localparam int V_SYNC   = 2;
  localparam int V_TOP    = 2;
  localparam int V_ACTIVE = 12;
  localparam int ROW_H    = 6;
  localparam int HB0      = H_SYNC + H_BACK;
  localparam int ACT0     = V_SYNC + V_TOP;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  vdg_frame_timing_if #(.CNT_W(CNT_W)) bus();

  vdg_frame_timing #(
    .CNT_W(CNT_W), .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE),
    .V_TOTAL_NTSC(VT_N), .V_TOTAL_PAL(VT_P), .V_SYNC(V_SYNC), .V_TOP(V_TOP),
    .V_ACTIVE(V_ACTIVE), .ROW_HEIGHT(ROW_H)
  ) dut (
    .i_Clk  (clk),
    .i_RSTn (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: beam position and the mode in force for the current frame.
  int       m_h, m_v;
  bit       m_fmt, m_ang, m_first;
  bit [2:0] m_gm;

  // Mode table indexed by GM when AnG=1: dots/byte, dots/pixel, lines/row.
  int dpb_t[8] = '{16, 16, 8, 16, 8, 16, 8, 8};
  int dpp_t[8] = '{4, 2, 2, 2, 2, 2, 2, 1};
  int lpr_t[8] = '{3, 3, 3, 2, 2, 1, 1, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic void mode_params(input bit ang, input bit [2:0] gm,
                                      output int dpb, output int dpp, output int lpr);
    if (!ang) begin
      dpb = 8; dpp = 1; lpr = ROW_H;
    end else begin
      dpb = dpb_t[gm]; dpp = dpp_t[gm]; lpr = lpr_t[gm];
    end
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_fmt = 1'b0; m_ang = 1'b0; m_gm = 3'd0; m_first = 1'b1;
  endtask

  task automatic chk_reset_values();
    chk("rst_HSn", bus.HSn, 1);
    chk("rst_FSn", bus.FSn, 1);
    chk("rst_BackPorch", bus.BackPorch, 0);
    chk("rst_Active", bus.Active, 0);
    chk("rst_Load", bus.Load, 0);
    chk("rst_PixelEn", bus.PixelEn, 0);
    chk("rst_DA0", bus.DA0, 0);
    chk("rst_AlphaRow", bus.AlphaRow, 0);
    chk("rst_RPn", bus.RPn, 1);
    chk("rst_HCount", bus.HCount, 0);
    chk("rst_VCount", bus.VCount, 0);
  endtask

  // One dot clock: predict flags from the pre-edge position, advance the model, compare after the edge.
  task automatic step();
    int dpb, dpp, lpr, d, vt;
    bit actl, win, latch, n_fmt, n_ang;
    bit [2:0] n_gm;
    bit e_hsn, e_bp, e_fsn, e_act, e_load, e_pix, e_rpn, e_da0;
    int e_row;
    mode_params(m_ang, m_gm, dpb, dpp, lpr);
    vt    = m_fmt ? VT_P : VT_N;
    actl  = (m_v >= ACT0) && (m_v < ACT0 + V_ACTIVE);
    win   = (m_h >= HB0) && (m_h < HB0 + H_ACTIVE);
    d     = m_h - HB0;
    e_hsn = (m_h >= H_SYNC);
    e_bp  = (m_h >= H_SYNC) && (m_h < HB0);
    e_fsn = (m_v >= V_SYNC);
    e_act = win && actl;
    e_load = e_act && (d % dpb == 0);
    e_pix  = e_act && (d % dpp == 0);
    e_rpn  = !(actl && ((m_v - ACT0) % lpr == 0) && !m_ang);
    e_da0  = (win && actl && d > 0) ? bit'((((d - 1) / dpb) + 1) % 2) : 1'b0;
    latch  = m_first || (m_h == H_TOTAL - 1 && m_v == vt - 1);
    n_fmt = bus.FrameFormat; n_ang = bus.AnG; n_gm = bus.GM;
    @(posedge clk);
    if (m_h == H_TOTAL - 1) begin
      m_h = 0;
      m_v = (m_v == vt - 1) ? 0 : m_v + 1;
    end else begin
      m_h = m_h + 1;
    end
    if (latch) begin
      m_fmt = n_fmt; m_ang = n_ang; m_gm = n_gm;
    end
    m_first = 1'b0;
    mode_params(m_ang, m_gm, dpb, dpp, lpr);
    e_row = ((m_v >= ACT0) && (m_v < ACT0 + V_ACTIVE)) ? (m_v - ACT0) % lpr : 0;
    @(negedge clk);
    chk("HSn", bus.HSn, e_hsn);
    chk("BackPorch", bus.BackPorch, e_bp);
    chk("FSn", bus.FSn, e_fsn);
    chk("Active", bus.Active, e_act);
    chk("Load", bus.Load, e_load);
    chk("PixelEn", bus.PixelEn, e_pix);
    chk("RPn", bus.RPn, e_rpn);
    if (win) chk("DA0", bus.DA0, e_da0);
    chk("AlphaRow", bus.AlphaRow, e_row);
    chk("HCount", bus.HCount, m_h);
    chk("VCount", bus.VCount, m_v);
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      step();
      if (rnd && $urandom_range(0, 63) == 0) begin
        bus.FrameFormat = 1'($urandom_range(0, 1));
        bus.AnG         = 1'($urandom_range(0, 1));
        bus.GM          = 3'($urandom_range(0, 7));
      end
    end
  endtask

  initial begin
    bit reached;
    bus.FrameFormat = 1'b0;
    bus.AnG         = 1'b0;
    bus.GM          = 3'd0;
    model_reset();
    #1 rst_n = 1'b0;
    #2 chk_reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    // NTSC alpha frames.
    run(2 * H_TOTAL * VT_N, 1'b0);
    // CG1 requested mid-frame: ignored until the next frame start.
    run(H_TOTAL * 7 + 13, 1'b0);
    bus.AnG = 1'b1; bus.GM = 3'd0;
    run(2 * H_TOTAL * VT_N, 1'b0);
    // PAL requested mid-frame: current frame keeps NTSC length; GM change also deferred.
    run(H_TOTAL * 5 + 21, 1'b0);
    bus.FrameFormat = 1'b1; bus.GM = 3'd7;
    run(3 * H_TOTAL * VT_P, 1'b0);
    // Random mode/format churn.
    run(7000, 1'b1);

    // Reset asserted while inside the active window of an active line.
    bus.FrameFormat = 1'b0; bus.AnG = 1'b0; bus.GM = 3'd0;
    reached = 1'b0;
    for (int i = 0; i < 3 * H_TOTAL * VT_P && !reached; i++) begin
      step();
      if (m_v >= ACT0 && m_v < ACT0 + V_ACTIVE && m_h >= HB0 + 3 && m_h < HB0 + 10) reached = 1'b1;
    end
    chk("reach_active_window", reached, 1);
    chk("pre_rst_Active", bus.Active, 1);
    rst_n = 1'b0;
    #1 chk_reset_values();
    @(negedge clk);
    chk_reset_values();
    bus.AnG = 1'b1; bus.GM = 3'd3;
    rst_n = 1'b1;
    model_reset();
    run(2 * H_TOTAL * VT_N, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
